// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard_ctrl pipeline sequencer.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
package hazard_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        MEM_WAIT,
        DRAIN,
        HALTED
    } hz_state_e;

    localparam int REG_ADDR_W       = 5;
    localparam int MEM_TIMEOUT_DEF  = 64;
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int PERF_CNT_W       = 32;

    // Width of a counter that must be able to hold max_val itself.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of hazard_ctrl; the controller uses the slave modport.
// Perf counter outputs exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if
    import hazard_pkg::*;
();
    logic                  start_i;
    logic                  IDEX_MemRead_i;
    logic [REG_ADDR_W-1:0] IDEX_Rd_i;
    logic [REG_ADDR_W-1:0] IFID_Rs1_i;
    logic [REG_ADDR_W-1:0] IFID_Rs2_i;
    logic                  IFID_UseRs1_i;
    logic                  IFID_UseRs2_i;
    logic                  Branch_taken_i;
    logic                  dmem_req_i;
    logic                  dmem_ready_i;
    logic                  halt_i;
    logic                  PCWrite_o;
    logic                  IFID_Write_o;
    logic                  IFID_Flush_o;
    logic                  IDEX_Bubble_o;
    logic                  Freeze_o;
    logic                  halted_o;
    logic                  err_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_cycles_o;
    logic [PERF_CNT_W-1:0] bubble_cnt_o;
    logic [PERF_CNT_W-1:0] flush_cnt_o;
`endif

    modport master (
        output start_i, IDEX_MemRead_i, IDEX_Rd_i, IFID_Rs1_i, IFID_Rs2_i,
               IFID_UseRs1_i, IFID_UseRs2_i, Branch_taken_i, dmem_req_i,
               dmem_ready_i, halt_i,
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cycles_o, bubble_cnt_o, flush_cnt_o,
`endif
        input  PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o,
               Freeze_o, halted_o, err_o
    );

    modport slave (
        input  start_i, IDEX_MemRead_i, IDEX_Rd_i, IFID_Rs1_i, IFID_Rs2_i,
               IFID_UseRs1_i, IFID_UseRs2_i, Branch_taken_i, dmem_req_i,
               dmem_ready_i, halt_i,
`ifdef HAZARD_PERF_CNT_EN
        output stall_cycles_o, bubble_cnt_o, flush_cnt_o,
`endif
        output PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o,
               Freeze_o, halted_o, err_o
    );

endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds
// an operand the ID instruction actually reads. x0 never creates a hazard.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic                  mem_read_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic                  use_rs1_i,
    input  logic                  use_rs2_i,
    output logic                  stall_o
);
    always_comb begin
        stall_o = mem_read_i && (rd_i != '0) &&
                  (((rd_i == rs1_i) && use_rs1_i) || ((rd_i == rs2_i) && use_rs2_i));
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF/ID / ID/EX update control, load-use
// bubbles, branch flush, memory freeze and halt drain. Macro: HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_ctrl_if.slave bus
);
    localparam int WAIT_W  = cnt_width(MEM_TIMEOUT);
    localparam int DRAIN_W = cnt_width(DRAIN_CYCLES);
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    hz_state_e          state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               err_q, err_d;

    logic load_use, mem_stall, eval_run;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, freeze, halted;

    load_use_detect u_load_use_detect (
        .mem_read_i (bus.IDEX_MemRead_i),
        .rd_i       (bus.IDEX_Rd_i),
        .rs1_i      (bus.IFID_Rs1_i),
        .rs2_i      (bus.IFID_Rs2_i),
        .use_rs1_i  (bus.IFID_UseRs1_i),
        .use_rs2_i  (bus.IFID_UseRs2_i),
        .stall_o    (load_use)
    );

    assign mem_stall = bus.dmem_req_i & ~bus.dmem_ready_i;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = err_q;
        eval_run    = 1'b0;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        freeze      = 1'b0;
        halted      = 1'b0;

        case (state_q)
            IDLE: begin
                idex_bubble = 1'b1;
                if (bus.start_i) state_d = RUN;
            end
            RUN: begin
                if (mem_stall) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    eval_run = 1'b1;
                end
            end
            MEM_WAIT: begin
                // The timeout only flags the error; the access is still awaited.
                if (!bus.dmem_ready_i) begin
                    freeze = 1'b1;
                    if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_d == WAIT_MAX) err_d = 1'b1;
                end else begin
                    wait_cnt_d = '0;
                    state_d    = RUN;
                    eval_run   = 1'b1;
                end
            end
            DRAIN: begin
                ifid_flush = 1'b1;
                if (mem_stall)               freeze      = 1'b1;
                else if (drain_cnt_q == '0)  state_d     = HALTED;
                else                         drain_cnt_d = drain_cnt_q - 1'b1;
            end
            HALTED: begin
                halted      = 1'b1;
                idex_bubble = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Load-use wins over branch and halt; those are re-evaluated next cycle.
        if (eval_run) begin
            if (load_use) begin
                idex_bubble = 1'b1;
            end else if (bus.Branch_taken_i) begin
                ifid_flush = 1'b1;
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end else if (bus.halt_i) begin
                ifid_flush  = 1'b1;
                state_d     = DRAIN;
                drain_cnt_d = DRAIN_LOAD;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            drain_cnt_q <= DRAIN_INIT;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.PCWrite_o     = pc_write;
    assign bus.IFID_Write_o  = ifid_write;
    assign bus.IFID_Flush_o  = ifid_flush;
    assign bus.IDEX_Bubble_o = idex_bubble;
    assign bus.Freeze_o      = freeze;
    assign bus.halted_o      = halted;
    assign bus.err_o         = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic                  in_run;

    // Bubble and flush counts only cover the executing states, not IDLE/DRAIN/HALTED.
    always_comb begin
        in_run       = (state_q == RUN) || (state_q == MEM_WAIT);
        stall_cnt_d  = stall_cnt_q  + PERF_CNT_W'(freeze);
        bubble_cnt_d = bubble_cnt_q + PERF_CNT_W'(idex_bubble & in_run);
        flush_cnt_d  = flush_cnt_q  + PERF_CNT_W'(ifid_flush & in_run);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bus.stall_cycles_o = stall_cnt_q;
    assign bus.bubble_cnt_o   = bubble_cnt_q;
    assign bus.flush_cnt_o    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=64, DRAIN_CYCLES=3).
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    hazard_ctrl_if bus_if ();

    hazard_ctrl #(
        .MEM_TIMEOUT  (64),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_if.slave)
    );

    // {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Freeze, halted, err}
    logic [6:0] outs;
    assign outs = {bus_if.PCWrite_o, bus_if.IFID_Write_o, bus_if.IFID_Flush_o,
                   bus_if.IDEX_Bubble_o, bus_if.Freeze_o, bus_if.halted_o, bus_if.err_o};

    typedef struct packed {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [6:0] exp;
    } lu_vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus_if.start_i        = 1'b0;
        bus_if.IDEX_MemRead_i = 1'b0;
        bus_if.IDEX_Rd_i      = '0;
        bus_if.IFID_Rs1_i     = '0;
        bus_if.IFID_Rs2_i     = '0;
        bus_if.IFID_UseRs1_i  = 1'b0;
        bus_if.IFID_UseRs2_i  = 1'b0;
        bus_if.Branch_taken_i = 1'b0;
        bus_if.dmem_req_i     = 1'b0;
        bus_if.dmem_ready_i   = 1'b0;
        bus_if.halt_i         = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        next_cycle();
        @(negedge clk);
        vectors++;
        if (outs !== 7'b0001000) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: got %b expected %b", outs, 7'b0001000);
        end
        bus_if.start_i = 1'b1;
        next_cycle();
        @(negedge clk);
        vectors++;
        if (outs !== 7'b0001000) begin
            miscompares++;
            $display("[TB] FAIL reset_overrides_start: got %b expected %b", outs, 7'b0001000);
        end
    endtask

    task automatic test_start;
        rst_n = 1'b1;
        next_cycle();
        bus_if.start_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (outs !== 7'b1100000) begin
            miscompares++;
            $display("[TB] FAIL run_entry: got %b expected %b", outs, 7'b1100000);
        end
    endtask

    task automatic test_load_use;
        lu_vec_t tbl [8];
        tbl[0] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 7'b0001000};
        tbl[1] = '{1'b0, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 7'b1100000};
        tbl[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 7'b1100000};
        tbl[3] = '{1'b1, 5'd9,  5'd3,  5'd9,  1'b1, 1'b0, 7'b1100000};
        tbl[4] = '{1'b1, 5'd9,  5'd3,  5'd9,  1'b0, 1'b1, 7'b0001000};
        tbl[5] = '{1'b1, 5'd9,  5'd9,  5'd4,  1'b0, 1'b1, 7'b1100000};
        tbl[6] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 7'b0001000};
        tbl[7] = '{1'b0, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 7'b1100000};
        for (int i = 0; i < 8; i++) begin
            bus_if.IDEX_MemRead_i = tbl[i].mr;
            bus_if.IDEX_Rd_i      = tbl[i].rd;
            bus_if.IFID_Rs1_i     = tbl[i].rs1;
            bus_if.IFID_Rs2_i     = tbl[i].rs2;
            bus_if.IFID_UseRs1_i  = tbl[i].u1;
            bus_if.IFID_UseRs2_i  = tbl[i].u2;
            @(negedge clk);
            vectors++;
            if (outs !== tbl[i].exp) begin
                miscompares++;
                $display("[TB] FAIL load_use[%0d]: got %b expected %b", i, outs, tbl[i].exp);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_branch_priority;
        bus_if.IDEX_MemRead_i = 1'b1;
        bus_if.IDEX_Rd_i      = 5'd7;
        bus_if.IFID_Rs2_i     = 5'd7;
        bus_if.IFID_UseRs2_i  = 1'b1;
        bus_if.Branch_taken_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== 7'b0001000) begin
            miscompares++;
            $display("[TB] FAIL lu_over_branch: got %b expected %b", outs, 7'b0001000);
        end
        next_cycle();
        bus_if.IDEX_MemRead_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (outs !== 7'b1110000) begin
            miscompares++;
            $display("[TB] FAIL branch_flush: got %b expected %b", outs, 7'b1110000);
        end
        next_cycle();
        bus_if.Branch_taken_i = 1'b0;
        bus_if.IDEX_MemRead_i = 1'b1;
        bus_if.halt_i         = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== 7'b0001000) begin
            miscompares++;
            $display("[TB] FAIL lu_over_halt: got %b expected %b", outs, 7'b0001000);
        end
        next_cycle();
        bus_if.IDEX_MemRead_i = 1'b0;
        bus_if.Branch_taken_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== 7'b1110000) begin
            miscompares++;
            $display("[TB] FAIL branch_over_halt: got %b expected %b", outs, 7'b1110000);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (outs !== 7'b1100000) begin
            miscompares++;
            $display("[TB] FAIL still_run: got %b expected %b", outs, 7'b1100000);
        end
        next_cycle();
    endtask

    task automatic test_mem_timeout;
        logic [6:0] exp;
        bus_if.dmem_req_i     = 1'b1;
        bus_if.dmem_ready_i   = 1'b0;
        bus_if.IDEX_MemRead_i = 1'b1;
        bus_if.IDEX_Rd_i      = 5'd5;
        bus_if.IFID_Rs1_i     = 5'd5;
        bus_if.IFID_UseRs1_i  = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== 7'b0000100) begin
            miscompares++;
            $display("[TB] FAIL mem_over_lu: got %b expected %b", outs, 7'b0000100);
        end
        next_cycle();
        bus_if.IDEX_MemRead_i = 1'b0;
        for (int k = 1; k < 70; k++) begin
            exp = {6'b000010, (k >= 64)};
            @(negedge clk);
            vectors++;
            if (outs !== exp) begin
                miscompares++;
                $display("[TB] FAIL mem_wait[%0d]: got %b expected %b", k, outs, exp);
            end
            next_cycle();
        end
        bus_if.dmem_ready_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== 7'b1100001) begin
            miscompares++;
            $display("[TB] FAIL mem_ready_release: got %b expected %b", outs, 7'b1100001);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (outs !== 7'b1100001) begin
            miscompares++;
            $display("[TB] FAIL err_sticky: got %b expected %b", outs, 7'b1100001);
        end
        next_cycle();
    endtask

    task automatic test_halt_drain;
        logic [6:0] exp_seq [6];
        exp_seq[0] = 7'b0010001;
        exp_seq[1] = 7'b0010101;
        exp_seq[2] = 7'b0010101;
        exp_seq[3] = 7'b0010001;
        exp_seq[4] = 7'b0010001;
        exp_seq[5] = 7'b0001011;
        bus_if.halt_i = 1'b1;
        @(negedge clk);
        vectors++;
        if ({outs[6], outs[4], outs[2]} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL halt_in_run: got %b expected %b", {outs[6], outs[4], outs[2]}, 3'b010);
        end
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            bus_if.dmem_req_i   = (c == 1) || (c == 2) || (c == 3);
            bus_if.dmem_ready_i = (c == 3);
            @(negedge clk);
            vectors++;
            if (outs !== exp_seq[c]) begin
                miscompares++;
                $display("[TB] FAIL drain[%0d]: got %b expected %b", c, outs, exp_seq[c]);
            end
        end
        next_cycle();
        clear_inputs();
        bus_if.start_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== 7'b0001011) begin
            miscompares++;
            $display("[TB] FAIL halted_sticky: got %b expected %b", outs, 7'b0001011);
        end
        rst_n = 1'b0;
        next_cycle();
        @(negedge clk);
        vectors++;
        if (outs !== 7'b0001000) begin
            miscompares++;
            $display("[TB] FAIL reset_from_halted: got %b expected %b", outs, 7'b0001000);
        end
        rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait;
        bus_if.start_i = 1'b1;
        next_cycle();
        bus_if.start_i      = 1'b0;
        bus_if.dmem_req_i   = 1'b1;
        bus_if.dmem_ready_i = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++;
        if (outs !== 7'b0000100) begin
            miscompares++;
            $display("[TB] FAIL mid_wait_freeze: got %b expected %b", outs, 7'b0000100);
        end
        rst_n = 1'b0;
        next_cycle();
        @(negedge clk);
        vectors++;
        if (outs !== 7'b0001000) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_wait: got %b expected %b", outs, 7'b0001000);
        end
        rst_n = 1'b1;
        bus_if.start_i = 1'b1;
        next_cycle();
        bus_if.start_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (outs !== 7'b0000100) begin
            miscompares++;
            $display("[TB] FAIL rerun_freeze: got %b expected %b", outs, 7'b0000100);
        end
        next_cycle();
        bus_if.dmem_ready_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== 7'b1100000) begin
            miscompares++;
            $display("[TB] FAIL wait_release_no_err: got %b expected %b", outs, 7'b1100000);
        end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        clear_inputs();
        test_reset();
        test_start();
        test_load_use();
        test_branch_priority();
        test_mem_timeout();
        test_halt_drain();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
